// File: rtl/roc_pkg.sv
// Shared types and constants for the RoC tick scheduler.
package roc_pkg;

    localparam int TICK_COUNT_W = 32;
    localparam int SETTLE_W     = 8;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_RUN   = 2'd1,
        OP_PAUSE = 2'd2,
        OP_STEP  = 2'd3
    } roc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP_WAIT = 2'd2,
        ST_SETTLE    = 2'd3
    } roc_sched_state_e;

endpackage

// File: rtl/roc_settle_timer.sv
// Down-counter loaded at tick issue; o_done is high in the last settle cycle.
module roc_settle_timer
    import roc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_done
);

    logic [SETTLE_W-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= SETTLE_W'(SETTLE_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Terminal count is 1 so done lands in the SETTLE_CYCLES-th cycle after load.
    assign o_done = (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/roc_tick_scheduler.sv
// Free-run / pause / single-step sequencer for the RoC datapath with settle-then-capture.
// Optional tick counter output enabled by defining ROC_TICK_COUNT_EN.
//
// state      | meaning
// IDLE       | paused, accepting commands, no ticks issued
// RUN        | free-running, one tick per strobe, accepting commands
// STEP_WAIT  | stepping, waiting for the next strobe while remaining > 0
// SETTLE     | tick issued, waiting for RoC outputs before capture
module roc_tick_scheduler
    import roc_pkg::*;
#(
    parameter int ROC_INPUTS    = 8,
    parameter int ROC_OUTPUTS   = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int STEP_W        = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_tick_strobe,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [1:0]             i_cmd_op,
    input  logic [STEP_W-1:0]      i_cmd_steps,
    input  logic [ROC_INPUTS-1:0]  i_roc_inputs,
    output logic [ROC_INPUTS-1:0]  o_roc_inputs,
    output logic                   o_roc_tick,
    input  logic [ROC_OUTPUTS-1:0] i_roc_outputs,
    output logic [ROC_OUTPUTS-1:0] o_out_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic                   o_running,
    output logic                   o_tick_miss,
    output logic                   o_overrun
`ifdef ROC_TICK_COUNT_EN
    ,
    output logic [TICK_COUNT_W-1:0] o_tick_count
`endif
);

    roc_sched_state_e  state_q, state_d;
    logic [STEP_W-1:0] remaining_q, remaining_d;
    logic              run_mode_q, run_mode_d;
    logic              issue;
    logic              cmd_fire;
    logic              settle_done;
    logic              capture;
    roc_op_e           op;

    assign op          = roc_op_e'(i_cmd_op);
    assign o_cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;
    assign capture     = (state_q == ST_SETTLE) && settle_done;
    assign o_running   = run_mode_q;

    roc_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (issue),
        .o_done (settle_done)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        run_mode_d  = run_mode_q;
        issue       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire && op == OP_RUN) begin
                    state_d    = ST_RUN;
                    run_mode_d = 1'b1;
                end else if (cmd_fire && op == OP_STEP && i_cmd_steps != '0) begin
                    state_d     = ST_STEP_WAIT;
                    remaining_d = i_cmd_steps;
                end
            end
            ST_RUN: begin
                // Mode-changing commands win over a same-cycle strobe.
                if (cmd_fire && op == OP_PAUSE) begin
                    state_d    = ST_IDLE;
                    run_mode_d = 1'b0;
                end else if (cmd_fire && op == OP_STEP) begin
                    run_mode_d = 1'b0;
                    if (i_cmd_steps != '0) begin
                        state_d     = ST_STEP_WAIT;
                        remaining_d = i_cmd_steps;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (i_tick_strobe) begin
                    state_d = ST_SETTLE;
                    issue   = 1'b1;
                end
            end
            ST_STEP_WAIT: begin
                if (i_tick_strobe) begin
                    state_d     = ST_SETTLE;
                    issue       = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_done) begin
                    if (run_mode_q) begin
                        state_d = ST_RUN;
                    end else if (remaining_q != '0) begin
                        state_d = ST_STEP_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            run_mode_q   <= 1'b0;
            o_roc_tick   <= 1'b0;
            o_roc_inputs <= '0;
            o_out_data   <= '0;
            o_out_valid  <= 1'b0;
            o_tick_miss  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            run_mode_q  <= run_mode_d;
            o_roc_tick  <= issue;
            if (issue) begin
                o_roc_inputs <= i_roc_inputs;
            end
            // A capture into an unconsumed slot is an overrun unless the slot drains this cycle.
            if (capture) begin
                o_out_data  <= i_roc_outputs;
                o_out_valid <= 1'b1;
                if (o_out_valid && !i_out_ready) begin
                    o_overrun <= 1'b1;
                end
            end else if (o_out_valid && i_out_ready) begin
                o_out_valid <= 1'b0;
            end
            if (state_q == ST_SETTLE && run_mode_q && i_tick_strobe) begin
                o_tick_miss <= 1'b1;
            end
        end
    end

`ifdef ROC_TICK_COUNT_EN
    logic [TICK_COUNT_W-1:0] tick_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tick_cnt_q <= '0;
        end else if (issue) begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    assign o_tick_count = tick_cnt_q;
`endif

endmodule
